clock_lock_supervisor: RTL and testbench

CLOCK_LOCK_SUPERVISOR -- requirements
Module: clock_lock_supervisor

---
 rtl/clock_sup_pkg.sv | 12 +
 rtl/clock_lock_supervisor_sync_2ff.sv | 22 ++
 rtl/clock_lock_supervisor.sv | 150 +++++++++++++++
 tb/tb_clock_lock_supervisor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/clock_sup_pkg.sv
// rtl/clock_sup_pkg.sv - supervisor state encoding shared by the clock lock supervisor files
package clock_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STAGGER   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

endpackage

// File: rtl/clock_lock_supervisor_sync_2ff.sv
// rtl/clock_lock_supervisor_sync_2ff.sv - two-flop synchroniser for one asynchronous lock bit
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the metastable first stage a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_lock_supervisor.sv
// rtl/clock_lock_supervisor.sv - MMCM reset/lock sequencer with staggered domain resets; CLOCK_SUP_RETRY_CNT_EN adds retry_cnt and lock_lost
module clock_lock_supervisor
  import clock_sup_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int STAGGER_CYCLES = 8,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNELS-1:0]                locked,
  output logic                               mmcm_rst,
  output logic [CHANNELS-1:0]                rst_out,
  output logic                               all_locked,
`ifdef CLOCK_SUP_RETRY_CNT_EN
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic                               lock_lost,
`endif
  output logic                               fault
);

  // One shared counter serves every timed state, so it is sized for the longest interval.
  localparam int STG_MAX = CHANNELS * STAGGER_CYCLES;
  localparam int CNT_MAX = (LOCK_TIMEOUT > STG_MAX)
                         ? ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES)
                         : ((STG_MAX > RST_CYCLES) ? STG_MAX : RST_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STG_MAX - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [RTY_W-1:0]    retry;
  logic [CHANNELS-1:0] lock_s;
  logic                loss;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (locked[g]),
      .q   (lock_s[g])
    );
  end

  assign loss = ((state == ST_STAGGER) || (state == ST_RUN)) && !(&lock_s);

`ifdef CLOCK_SUP_RETRY_CNT_EN
  logic lost;
  assign retry_cnt = retry;
  assign lock_lost = lost;
`endif

  // Sequencer: pulse MMCM reset, wait for lock with retries, then release domains one by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RESET;
      cnt        <= '0;
      retry      <= '0;
      mmcm_rst   <= 1'b1;
      rst_out    <= '1;
      all_locked <= 1'b0;
      fault      <= 1'b0;
`ifdef CLOCK_SUP_RETRY_CNT_EN
      lost       <= 1'b0;
`endif
    end else begin
`ifdef CLOCK_SUP_RETRY_CNT_EN
      lost <= 1'b0;
`endif
      if (loss) begin
        // A dropped lock restarts the sequence without spending a retry.
        state      <= ST_RESET;
        cnt        <= '0;
        mmcm_rst   <= 1'b1;
        rst_out    <= '1;
        all_locked <= 1'b0;
`ifdef CLOCK_SUP_RETRY_CNT_EN
        lost       <= 1'b1;
`endif
      end else begin
        case (state)
          ST_RESET: begin
            mmcm_rst <= 1'b1;
            if (cnt == RST_LAST) begin
              state    <= ST_WAIT_LOCK;
              mmcm_rst <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_WAIT_LOCK: begin
            if (&lock_s) begin
              state <= ST_STAGGER;
              cnt   <= '0;
            end else if (cnt == TO_LAST) begin
              cnt      <= '0;
              mmcm_rst <= 1'b1;
              retry    <= retry + RTY_W'(1);
              if (retry == RTY_LAST) begin
                state <= ST_FAULT;
                fault <= 1'b1;
              end else begin
                state <= ST_RESET;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_STAGGER: begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (cnt == CNT_W'((i + 1) * STAGGER_CYCLES - 1)) begin
                rst_out[i] <= 1'b0;
              end
            end
            if (cnt == STG_LAST) begin
              state      <= ST_RUN;
              all_locked <= 1'b1;
              retry      <= '0;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RUN: begin
            all_locked <= 1'b1;
          end
          ST_FAULT: begin
            mmcm_rst   <= 1'b1;
            rst_out    <= '1;
            all_locked <= 1'b0;
            fault      <= 1'b1;
          end
          default: begin
            state <= ST_RESET;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_lock_supervisor.sv
// tb/tb_clock_lock_supervisor.sv - scoreboard bench for clock_lock_supervisor
module tb_clock_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] locked = 2'b00;
  logic       mmcm_rst;
  logic [1:0] rst_out;
  logic       all_locked;
  logic       fault;
`ifdef CLOCK_SUP_RETRY_CNT_EN
  logic [1:0] retry_cnt;
  logic       lock_lost;
`endif

  clock_lock_supervisor #(
    .CHANNELS       (2),
    .RST_CYCLES     (4),
    .LOCK_TIMEOUT   (20),
    .STAGGER_CYCLES (3),
    .MAX_RETRIES    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .mmcm_rst   (mmcm_rst),
    .rst_out    (rst_out),
    .all_locked (all_locked),
`ifdef CLOCK_SUP_RETRY_CNT_EN
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost),
`endif
    .fault      (fault)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         at;
    logic [4:0] exp;
    logic [2:0] ext;
    bit         use_ext;
  } item_t;

  item_t sb[$];
  item_t cur;
  int    cyc = 0;
  int    c0 = 0;
  int    tests = 0;
  int    fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pop every expectation due at this cycle and compare {mmcm_rst, rst_out, all_locked, fault}.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      tests++;
      assert (cur.at == cyc && {mmcm_rst, rst_out, all_locked, fault} === cur.exp)
        else begin
          fails++;
          $error("FAIL %s cycle=%0d due=%0d observed=%b expected=%b", cur.tag, cyc, cur.at,
                 {mmcm_rst, rst_out, all_locked, fault}, cur.exp);
        end
`ifdef CLOCK_SUP_RETRY_CNT_EN
      if (cur.use_ext) begin
        tests++;
        assert ({retry_cnt, lock_lost} === cur.ext)
          else begin
            fails++;
            $error("FAIL %s_ext observed=%b expected=%b", cur.tag, {retry_cnt, lock_lost}, cur.ext);
          end
      end
`endif
    end
  end

  task automatic expect_at(input string tag, input int off, input logic [4:0] exp,
                           input logic [2:0] ext, input bit use_ext);
    item_t it;
    it.tag = tag;
    it.at = c0 + off;
    it.exp = exp;
    it.ext = ext;
    it.use_ext = use_ext;
    sb.push_back(it);
  endtask

  task automatic go(input int n);
    while (cyc < c0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [1:0] lk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    locked = lk;
    repeat (2) @(posedge clk);
    #1;
    c0 = cyc;
    expect_at("reset_values", 0, 5'b1_11_0_0, 3'b000, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    // Clean start, then lock loss on channel 1, then a partial-lock retry loop.
    start(2'b00);
    expect_at("clean_mmcm_hold", 3, 5'b1_11_0_0, 3'b000, 1'b0);
    expect_at("clean_mmcm_low", 4, 5'b0_11_0_0, 3'b000, 1'b0);
    expect_at("clean_pre_stagger", 13, 5'b0_11_0_0, 3'b000, 1'b0);
    expect_at("clean_rst0_release", 14, 5'b0_10_0_0, 3'b000, 1'b0);
    expect_at("clean_rst0_only", 16, 5'b0_10_0_0, 3'b000, 1'b0);
    expect_at("clean_run", 17, 5'b0_00_1_0, 3'b000, 1'b1);
    expect_at("loss_sync_delay", 22, 5'b0_00_1_0, 3'b000, 1'b0);
    expect_at("loss_reset", 23, 5'b1_11_0_0, 3'b001, 1'b1);
    expect_at("loss_pulse_end", 24, 5'b1_11_0_0, 3'b000, 1'b1);
    expect_at("loss_reset_len", 26, 5'b1_11_0_0, 3'b000, 1'b0);
    expect_at("loss_wait", 27, 5'b0_11_0_0, 3'b000, 1'b0);
    expect_at("partial_timeout", 47, 5'b1_11_0_0, 3'b010, 1'b1);
    expect_at("partial_rewait", 51, 5'b0_11_0_0, 3'b010, 1'b1);
    expect_at("partial_hold", 70, 5'b0_11_0_0, 3'b010, 1'b0);
    go(8);
    locked = 2'b11;
    go(20);
    locked = 2'b01;
    go(70);

    // One timeout, then lock on the second attempt.
    start(2'b00);
    expect_at("retry_wait_end", 23, 5'b0_11_0_0, 3'b000, 1'b0);
    expect_at("retry_pulse", 24, 5'b1_11_0_0, 3'b010, 1'b1);
    expect_at("retry_pulse_len", 27, 5'b1_11_0_0, 3'b010, 1'b0);
    expect_at("retry_rewait", 28, 5'b0_11_0_0, 3'b010, 1'b0);
    expect_at("retry_stagger", 36, 5'b0_10_0_0, 3'b010, 1'b1);
    expect_at("retry_run", 39, 5'b0_00_1_0, 3'b000, 1'b1);
    go(30);
    locked = 2'b11;
    go(39);

    // Retries exhausted: sticky fault, late lock ignored.
    start(2'b00);
    expect_at("fault_pre", 47, 5'b0_11_0_0, 3'b010, 1'b0);
    expect_at("fault_enter", 48, 5'b1_11_0_1, 3'b100, 1'b1);
    expect_at("fault_sticky", 60, 5'b1_11_0_1, 3'b100, 1'b1);
    go(50);
    locked = 2'b11;
    go(60);

    // Asynchronous reset while only channel 0 is released.
    start(2'b11);
    expect_at("midstg_wait", 4, 5'b0_11_0_0, 3'b000, 1'b0);
    expect_at("midstg_enter", 5, 5'b0_11_0_0, 3'b000, 1'b0);
    expect_at("midstg_rst0", 8, 5'b0_10_0_0, 3'b000, 1'b0);
    expect_at("midstg_async_rst", 9, 5'b1_11_0_0, 3'b000, 1'b1);
    expect_at("midstg_rst_hold", 12, 5'b1_11_0_0, 3'b000, 1'b1);
    go(9);
    rst = 1'b1;
    go(12);

    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s never checked (due=%0d)", cur.tag, cur.at);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
